// File: rtl/spi_master.sv
// Mode-0 (CPOL=0, CPHA=0) transmit-only SPI master: one byte per start pulse,
// MSB first, framed by active-low SS with a programmable post-frame hold.
module spi_master #(
    parameter int CLK_DIV = 4,
    parameter int SS_HOLD = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       SCLK,
    output logic       MOSI,
    output logic       SS
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int HOLD_W = (SS_HOLD > 1) ? $clog2(SS_HOLD) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SS_HOLD - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]        state;
    logic [7:0]        shreg;
    logic [2:0]        bitcnt;
    logic [DIV_W-1:0]  divider;
    logic [HOLD_W-1:0] hold_cnt;

    // MOSI is the top of the shift register, so it is registered and only
    // moves when the register shifts on a falling SCLK edge.
    assign MOSI = shreg[7];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= 8'h00;
            bitcnt   <= 3'd0;
            divider  <= '0;
            hold_cnt <= '0;
            SCLK     <= 1'b0;
            SS       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= data;
                        SS      <= 1'b0;
                        divider <= '0;
                        bitcnt  <= 3'd0;
                        state   <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (divider == DIV_LAST) begin
                        divider <= '0;
                        SCLK    <= ~SCLK;
                        // SCLK currently high: this edge is the falling edge
                        if (SCLK) begin
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) begin
                                hold_cnt <= '0;
                                state    <= HOLD;
                            end else begin
                                shreg <= {shreg[6:0], 1'b0};
                            end
                        end
                    end else begin
                        divider <= divider + DIV_W'(1);
                    end
                end

                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        SS       <= 1'b1;
                        shreg    <= 8'h00;
                        state    <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: directed frames plus random bytes, with a
// bus monitor that decodes MOSI on SCLK rises and checks SCLK timing.
module tb_spi_master;

    localparam int CLK_DIV = 4;
    localparam int SS_HOLD = 2;
    localparam int FRAME   = 1 + 16 * CLK_DIV + SS_HOLD;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       SCLK;
    logic       MOSI;
    logic       SS;

    int compared   = 0;
    int mismatched = 0;

    logic       prevSclk  = 1'b0;
    logic       prevMosi  = 1'b0;
    logic       prevSs    = 1'b1;
    int         rises     = 0;
    int         ssFalls   = 0;
    int         runLen    = 0;
    bit         runValid  = 1'b0;
    logic [7:0] cap       = 8'h00;

    spi_master #(.CLK_DIV(CLK_DIV), .SS_HOLD(SS_HOLD)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .data (data),
        .SCLK (SCLK),
        .MOSI (MOSI),
        .SS   (SS)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave-side view of the bus, sampled on the falling clk edge.
    always @(negedge clk) begin
        if (reset) begin
            rises    = 0;
            cap      = 8'h00;
            runValid = 1'b0;
            runLen   = 0;
        end else begin
            if (SS === 1'b1) begin
                checkOutput("sclk_idle_low", {31'd0, SCLK}, 32'd0);
                runValid = 1'b0;
            end
            if (SS === 1'b0 && prevSs === 1'b1)
                ssFalls++;
            if (SCLK === 1'b1 && prevSclk === 1'b0 && SS === 1'b0) begin
                cap = {cap[6:0], MOSI};
                rises++;
            end
            if (SCLK === 1'b1 && prevSclk === 1'b1)
                checkOutput("mosi_stable", {31'd0, MOSI}, {31'd0, prevMosi});
            if (SCLK !== prevSclk) begin
                if (runValid)
                    checkOutput(SCLK ? "sclk_low_width" : "sclk_high_width", runLen, CLK_DIV);
                runValid = (SS === 1'b0);
                runLen   = 1;
            end else begin
                runLen++;
            end
        end
        prevSclk = SCLK;
        prevMosi = MOSI;
        prevSs   = SS;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits for SS to return high; tail=1/2 raises start on the SS-return edge.
    task automatic waitFrame(input int tail, inout int edges);
        while (SS !== 1'b1 && edges < FRAME + 20) begin
            if (tail > 0 && edges == FRAME - 1) begin
                start = 1'b1;
                data  = 8'h5A;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        if (tail == 1)
            start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input int hold, input logic [7:0] dAfter,
                                 input int tail, output int edges);
        rises   = 0;
        cap     = 8'h00;
        ssFalls = 0;
        start   = 1'b1;
        data    = d;
        @(posedge clk);
        #1;
        checkOutput("ss_fall_latency", {31'd0, SS}, 32'd0);
        edges = 1;
        for (int i = 1; i < hold; i++) begin
            @(posedge clk);
            #1;
            edges++;
        end
        start = 1'b0;
        data  = dAfter;
        waitFrame(tail, edges);
    endtask

    task automatic checkFrame(input logic [7:0] d, input int edges);
        checkOutput("frame_len", edges, FRAME);
        checkOutput("rx_byte", {24'd0, cap}, {24'd0, d});
        checkOutput("sclk_rises", rises, 8);
        idle(5);
        checkOutput("one_frame_only", ssFalls, 1);
        checkOutput("idle_mosi", {31'd0, MOSI}, 32'd0);
    endtask

    initial begin
        int         edges;
        int         waited;
        logic [7:0] t2Bytes [5];
        logic [7:0] d;
        logic [7:0] dAfter;

        t2Bytes = '{8'h03, 8'h08, 8'hAA, 8'h55, 8'hFF};

        repeat (5) @(posedge clk);
        #1;
        checkOutput("reset_ss", {31'd0, SS}, 32'd1);
        checkOutput("reset_sclk", {31'd0, SCLK}, 32'd0);
        checkOutput("reset_mosi", {31'd0, MOSI}, 32'd0);
        reset = 1'b0;
        idle(2);

        $display("[TB] T1 single frame 0xFA");
        applyStimulus(8'hFA, 1, 8'hFA, 0, edges);
        checkFrame(8'hFA, edges);

        $display("[TB] T2 back-to-back frames");
        foreach (t2Bytes[i]) begin
            applyStimulus(t2Bytes[i], 1, t2Bytes[i], 0, edges);
            checkFrame(t2Bytes[i], edges);
        end

        $display("[TB] T3 start held for three cycles");
        applyStimulus(8'h81, 3, 8'h81, 0, edges);
        checkFrame(8'h81, edges);
        idle(10);
        checkOutput("t3_no_second_frame", ssFalls, 1);

        $display("[TB] T4 data changed mid-frame");
        applyStimulus(8'h3C, 1, 8'hC3, 0, edges);
        checkFrame(8'h3C, edges);

        $display("[TB] start on the SS-return edge");
        applyStimulus(8'h96, 1, 8'h96, 1, edges);
        checkFrame(8'h96, edges);
        applyStimulus(8'h69, 1, 8'h69, 2, edges);
        checkOutput("tail_frame_len", edges, FRAME);
        checkOutput("tail_rx_byte", {24'd0, cap}, 32'h69);
        @(posedge clk);
        #1;
        checkOutput("tail_accept_next", {31'd0, SS}, 32'd0);
        start   = 1'b0;
        rises   = 0;
        cap     = 8'h00;
        ssFalls = 0;
        edges   = 1;
        waitFrame(0, edges);
        checkFrame(8'h5A, edges);

        $display("[TB] T5 reset mid-frame");
        start = 1'b1;
        data  = 8'hAA;
        @(posedge clk);
        #1;
        start  = 1'b0;
        waited = 0;
        while (rises < 3 && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("t5_third_rise_seen", {31'd0, rises >= 3}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_ss", {31'd0, SS}, 32'd1);
        checkOutput("abort_sclk", {31'd0, SCLK}, 32'd0);
        checkOutput("abort_mosi", {31'd0, MOSI}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);
        checkOutput("abort_no_resume", {31'd0, SS}, 32'd1);
        applyStimulus(8'h55, 1, 8'h55, 0, edges);
        checkFrame(8'h55, edges);

        $display("[TB] random frames");
        for (int k = 0; k < 8; k++) begin
            d      = 8'($urandom);
            dAfter = 8'($urandom);
            applyStimulus(d, $urandom_range(1, 3), dAfter, 0, edges);
            checkFrame(d, edges);
            idle($urandom_range(0, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
